// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: a DEPTH-entry circular buffer
// of {instr, pc, pc+4} with a first-word-fall-through head and flush on redirect.
module fetch_queue #(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         InstrF,
  input  logic [WIDTH-1:0]         PCF,
  input  logic [WIDTH-1:0]         PCPlus4F,
  input  logic                     pop_ready,
  output logic                     pop_valid,
  output logic [WIDTH-1:0]         InstrD,
  output logic [WIDTH-1:0]         PCD,
  output logic [WIDTH-1:0]         PCPlus4D,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] instr_mem_r [DEPTH];
  logic [WIDTH-1:0] pc_mem_r    [DEPTH];
  logic [WIDTH-1:0] pc4_mem_r   [DEPTH];

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic          empty_s;
  logic          full_s;
  logic          push_fire_s;
  logic          pop_fire_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;

  assign wr_idx_s    = wr_ptr_r[AW-1:0];
  assign rd_idx_s    = rd_ptr_r[AW-1:0];
  // The extra pointer MSB separates the full case from the empty case.
  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign full_s      = (wr_idx_s == rd_idx_s) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign push_ready  = !full_s;
  assign pop_valid   = !empty_s;
  assign push_fire_s = push_valid && !full_s;
  assign pop_fire_s  = pop_ready && !empty_s;
  assign count       = wr_ptr_r - rd_ptr_r;

  // Pointer update: reset, then flush, then normal push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= wr_ptr_r;
    end else begin
      if (push_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Entry storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_fire_s) begin
      instr_mem_r[wr_idx_s] <= InstrF;
      pc_mem_r[wr_idx_s]    <= PCF;
      pc4_mem_r[wr_idx_s]   <= PCPlus4F;
    end
  end

  // FWFT head: show the entry at rd_ptr, else a NOP bubble.
  always_comb begin
    InstrD   = NOP_INSTR[WIDTH-1:0];
    PCD      = {WIDTH{1'b0}};
    PCPlus4D = {WIDTH{1'b0}};
    if (!empty_s) begin
      InstrD   = instr_mem_r[rd_idx_s];
      PCD      = pc_mem_r[rd_idx_s];
      PCPlus4D = pc4_mem_r[rd_idx_s];
    end else begin
      InstrD   = NOP_INSTR[WIDTH-1:0];
      PCD      = {WIDTH{1'b0}};
      PCPlus4D = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference queue model tracks expected contents
// and every cycle the DUT head, count and handshakes are compared against it.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] InstrF = 32'h0;
  logic [31:0] PCF = 32'h0;
  logic [31:0] PCPlus4F = 32'h0;
  logic        pop_ready = 1'b0;
  logic        pop_valid;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [2:0]  count;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } entry_t;

  entry_t model_q[$];
  int     errors = 0;
  int     checks = 0;
  logic   checking = 1'b0;

  fetch_queue #(.WIDTH(32), .DEPTH(DEPTH), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .pop_ready(pop_ready), .pop_valid(pop_valid),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare DUT against the model, then advance both.
  task automatic step(input logic r, input logic fl, input logic pv, input logic pr,
                      input logic [31:0] instr, input logic [31:0] pc);
    entry_t e;
    logic   push_fire;
    logic   pop_fire;
    rst = r; flush = fl; push_valid = pv; pop_ready = pr;
    InstrF = instr; PCF = pc; PCPlus4F = pc + 32'd4;
    #1;
    if (checking) begin
      check("count", {29'd0, count}, 32'(model_q.size()));
      check("push_ready", {31'd0, push_ready}, {31'd0, model_q.size() < DEPTH});
      check("pop_valid", {31'd0, pop_valid}, {31'd0, model_q.size() > 0});
      if (model_q.size() > 0) begin
        check("InstrD", InstrD, model_q[0].instr);
        check("PCD", PCD, model_q[0].pc);
        check("PCPlus4D", PCPlus4D, model_q[0].pc4);
      end else begin
        check("InstrD_nop", InstrD, 32'h00000013);
        check("PCD_zero", PCD, 32'h0);
        check("PCPlus4D_zero", PCPlus4D, 32'h0);
      end
    end
    push_fire = pv && (model_q.size() < DEPTH);
    pop_fire  = pr && (model_q.size() > 0);
    @(posedge clk);
    if (r || fl) begin
      model_q.delete();
    end else begin
      if (pop_fire) void'(model_q.pop_front());
      if (push_fire) begin
        e.instr = instr; e.pc = pc; e.pc4 = pc + 32'd4;
        model_q.push_back(e);
      end
    end
    checking = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset, then idle.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Single push then pop.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h00500093, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Fill under stall, overflow attempt, then drain.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h00100013 + 32'(i), 32'(i * 4));
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Wrap-around with alternating decode stalls.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 1'b1, (i % 3) != 0, 32'h00200013 + 32'(i), 32'h100 + 32'(i * 4));
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Flush with a same-cycle push and pop.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h00300013 + 32'(i), 32'h200 + 32'(i * 4));
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h00399993, 32'h300);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Simultaneous push/pop at count==1.
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h00400013, 32'h400);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h00400113, 32'h404);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h00400213, 32'h408);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Reset with count==3, push and pop ignored at that edge.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h00500013 + 32'(i), 32'h500 + 32'(i * 4));
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h00599993, 32'h600);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h00600013, 32'h700);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue that sits directly downstream of the fetch stage, between fetch and decode.
- Buffers fetched {instruction, PC, PC+4} triples so fetch keeps running while decode is stalled by the hazard unit.
- Fetch's enable is driven from push_ready. Decode consumes the head entry as a first-word-fall-through (FWFT) output.
- On a taken branch or jump resolved in execute, the queue is flushed so wrong-path instructions never reach decode.

Parameters:
- WIDTH, 32, data/address width of instruction and PC fields.
- DEPTH, 4, number of entries. Must be a power of 2 and >= 2.
- NOP_INSTR, 32'h00000013, instruction presented on InstrD when empty (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  discard all entries (driven high when PCSrcE != 2'b00)
- push_valid  input  1  fetch presents a valid instruction this cycle
- push_ready  output  1  queue can accept an entry; drives fetch en
- InstrF  input  WIDTH  fetched instruction word
- PCF  input  WIDTH  PC of InstrF
- PCPlus4F  input  WIDTH  PCF+4
- pop_ready  input  1  decode accepts head entry (= ~StallD)
- pop_valid  output  1  head entry valid
- InstrD  output  WIDTH  head instruction, or NOP_INSTR when empty
- PCD  output  WIDTH  head PC, 0 when empty
- PCPlus4D  output  WIDTH  head PC+4, 0 when empty
- count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage: DEPTH-entry circular buffer of {InstrF, PCF, PCPlus4F}.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits. Index uses the low bits; the MSB distinguishes full from empty.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and MSBs differ.
- Reset (rst=1 at clock edge): wr_ptr=0, rd_ptr=0, count=0. Outputs next cycle: pop_valid=0, push_ready=1, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0. Storage contents are don't-care.
- rst mid-operation: all entries dropped at that edge, same as reset. Push and pop in that cycle are ignored.
- push_ready = !full (combinational from state). Does not depend on pop_ready; no pass-through when full.
- pop_valid = !empty (combinational from state).
- Push fires when push_valid && push_ready: write the entry at wr_ptr, wr_ptr++.
- Pop fires when pop_valid && pop_ready: rd_ptr++.
- Pointers wrap naturally modulo 2*DEPTH.
- Latency: an entry pushed at edge N is visible on InstrD/PCD/PCPlus4D and pop_valid immediately after edge N (one cycle). No bypass when empty.
- Outputs are FWFT: InstrD/PCD/PCPlus4D show the entry at rd_ptr combinationally while pop_valid=1, otherwise NOP_INSTR/0/0.
- Simultaneous push and pop: both fire and count is unchanged. When count==1, the new entry becomes head after the edge.
- Push while empty with pop_ready=1: only the push fires (pop_valid=0).
- Full with push_valid=1: no write, entry not consumed. Fetch is held because push_ready=0 drives en=0.
- Flush (priority below rst, above push/pop): at the edge rd_ptr <= wr_ptr' where wr_ptr' = wr_ptr. Queue is empty next cycle.
  - Any same-cycle push and pop are ignored.
  - The redirected PC's instruction arrives in a later cycle.
- count = wr_ptr - rd_ptr (modulo pointer width), range 0..DEPTH.
- No X on outputs after reset under any input sequence.

Test Plan:
- Reset then idle: rst=1 one cycle, push_valid=0 -> pop_valid=0, push_ready=1, InstrD=32'h00000013, PCD=0, count=0.
- Single push and pop: push InstrF=32'h00500093, PCF=0x0, PCPlus4F=0x4 with pop_ready=1 -> next cycle pop_valid=1, InstrD=32'h00500093, PCD=0, PCPlus4D=4. Cycle after that: empty, InstrD=NOP.
- Fill under stall: pop_ready=0, push PCs 0x0,0x4,0x8,0xC -> count=4, push_ready=0. A 5th push (PC 0x10) is not stored. Release pop_ready -> PCD sequence 0x0,0x4,0x8,0xC, then empty.
- Wrap-around: continuous push+pop of 10 instructions with alternating pop_ready stalls -> output order identical to input order, count never exceeds 4, no loss or duplication.
- Flush: 3 entries queued, assert flush together with push_valid=1 and pop_ready=1 -> next cycle count=0, pop_valid=0, InstrD=NOP. The pushed entry is absent.
- Simultaneous push/pop at count=1 and reset mid-fill: count stays 1 and the head advances to the new PC. Asserting rst with count=3 -> count=0, push_ready=1 next cycle.
